// File: rtl/flit_sender.sv
// Output stage of the mesh switch: pops flits from the input FIFO, XY-routes each
// packet wormhole-style and offers every flit on the port chosen by its head flit.
module flit_sender #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned X_SIZE    = 4,
  parameter int unsigned Y_SIZE    = 4,
  parameter int unsigned NODE_ADDR = 0,
  localparam int unsigned PORTS_NUM = 4,
  localparam int unsigned BUS_SIZE  = DATA_SIZE + ADDR_SIZE + 1
) (
  input  logic                              clk,
  input  logic                              a_rst,
  input  logic                              is_empty,
  input  logic [BUS_SIZE-1:0]               data_i,
  output logic                              rd_req,
  input  logic [PORTS_NUM:0]                r_ready_in,
  output logic [PORTS_NUM:0]                wr_ready_out,
  output logic [(PORTS_NUM+1)*BUS_SIZE-1:0] data_o,
  output logic                              drop_o
);

  localparam int unsigned N_PORTS = PORTS_NUM + 1;
  localparam int unsigned PORT_W  = $clog2(N_PORTS);
  localparam int unsigned OUT_W   = N_PORTS * BUS_SIZE;
  localparam int unsigned NODES   = X_SIZE * Y_SIZE;

  localparam logic [ADDR_SIZE-1:0] XS = ADDR_SIZE'(X_SIZE);
  localparam logic [ADDR_SIZE-1:0] CX = ADDR_SIZE'(NODE_ADDR % X_SIZE);
  localparam logic [ADDR_SIZE-1:0] CY = ADDR_SIZE'(NODE_ADDR / X_SIZE);

  localparam logic [PORT_W-1:0] PORT_E = PORT_W'(0);
  localparam logic [PORT_W-1:0] PORT_W_ = PORT_W'(1);
  localparam logic [PORT_W-1:0] PORT_S = PORT_W'(2);
  localparam logic [PORT_W-1:0] PORT_N = PORT_W'(3);
  localparam logic [PORT_W-1:0] PORT_L = PORT_W'(4);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] SEND    = 2'd3;

  logic [1:0]          state_q, state_nxt;
  logic                locked_q, locked_nxt;
  logic                dropping_q, dropping_nxt;
  logic [PORT_W-1:0]   port_q, port_nxt;
  logic [BUS_SIZE-1:0] flit_q, flit_nxt;
  logic                rd_req_nxt, drop_nxt;
  logic [N_PORTS-1:0]  wr_ready_nxt;
  logic [OUT_W-1:0]    data_o_nxt;

  logic [ADDR_SIZE-1:0] dest_c, dx_c, dy_c;
  logic [PORT_W-1:0]    route_c;
  logic                 unroutable_c;
  logic                 send_c, drop_now_c;
  logic [BUS_SIZE-1:0]  out_flit_c;

  // XY dimension-order route of the flit currently on data_i
  always_comb begin
    dest_c = data_i[ADDR_SIZE-1:0];
    dx_c   = dest_c % XS;
    dy_c   = dest_c / XS;
    if (dx_c > CX)      route_c = PORT_E;
    else if (dx_c < CX) route_c = PORT_W_;
    else if (dy_c > CY) route_c = PORT_S;
    else if (dy_c < CY) route_c = PORT_N;
    else                route_c = PORT_L;
    unroutable_c = 32'(dest_c) >= NODES;
  end

  // Next state and next registered outputs
  always_comb begin
    state_nxt    = state_q;
    locked_nxt   = locked_q;
    dropping_nxt = dropping_q;
    port_nxt     = port_q;
    flit_nxt     = flit_q;
    rd_req_nxt   = 1'b0;
    drop_nxt     = 1'b0;
    wr_ready_nxt = '0;
    data_o_nxt   = '0;
    send_c       = 1'b0;
    drop_now_c   = 1'b0;
    out_flit_c   = flit_q;

    case (state_q)
      IDLE: begin
        if (!is_empty) begin
          state_nxt  = FETCH;
          rd_req_nxt = 1'b1;
        end
      end
      FETCH: state_nxt = CAPTURE;
      CAPTURE: begin
        flit_nxt   = data_i;
        drop_now_c = dropping_q;
        if (!locked_q) begin
          locked_nxt = 1'b1;
          port_nxt   = route_c;
          if (unroutable_c) begin
            drop_now_c   = 1'b1;
            dropping_nxt = 1'b1;
          end
        end
        if (drop_now_c) begin
          state_nxt = IDLE;
          if (data_i[ADDR_SIZE]) begin
            drop_nxt     = 1'b1;
            dropping_nxt = 1'b0;
            locked_nxt   = 1'b0;
          end
        end else begin
          state_nxt  = SEND;
          send_c     = 1'b1;
          out_flit_c = data_i;
        end
      end
      SEND: begin
        // Only the accept of the selected port ends the offer
        if (r_ready_in[port_q]) begin
          state_nxt = IDLE;
          if (flit_q[ADDR_SIZE]) locked_nxt = 1'b0;
        end else begin
          send_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (send_c) begin
      wr_ready_nxt = N_PORTS'(1) << port_nxt;
      for (int p = 0; p < int'(N_PORTS); p++) begin
        if (port_nxt == PORT_W'(p)) data_o_nxt[p*BUS_SIZE +: BUS_SIZE] = out_flit_c;
      end
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q      <= IDLE;
      locked_q     <= 1'b0;
      dropping_q   <= 1'b0;
      port_q       <= PORT_L;
      flit_q       <= '0;
      rd_req       <= 1'b0;
      drop_o       <= 1'b0;
      wr_ready_out <= '0;
      data_o       <= '0;
    end else begin
      state_q      <= state_nxt;
      locked_q     <= locked_nxt;
      dropping_q   <= dropping_nxt;
      port_q       <= port_nxt;
      flit_q       <= flit_nxt;
      rd_req       <= rd_req_nxt;
      drop_o       <= drop_nxt;
      wr_ready_out <= wr_ready_nxt;
      data_o       <= data_o_nxt;
    end
  end

endmodule

// File: tb/tb_flit_sender.sv
// Scoreboard bench for flit_sender on a 4x4 mesh, node 5, 5-bit addresses.
module tb_flit_sender;

  localparam int BUS = 38;
  localparam int NP  = 5;
  localparam int DW  = NP * BUS;

  logic           clk = 1'b0;
  logic           a_rst = 1'b0;
  logic           is_empty;
  logic [BUS-1:0] data_i = '0;
  logic           rd_req;
  logic [NP-1:0]  r_ready_in = '0;
  logic [NP-1:0]  wr_ready_out;
  logic [DW-1:0]  data_o;
  logic           drop_o;

  always #5 clk = ~clk;

  flit_sender #(.DATA_SIZE(32), .ADDR_SIZE(5), .X_SIZE(4), .Y_SIZE(4), .NODE_ADDR(5)) dut (
    .clk(clk), .a_rst(a_rst), .is_empty(is_empty), .data_i(data_i), .rd_req(rd_req),
    .r_ready_in(r_ready_in), .wr_ready_out(wr_ready_out), .data_o(data_o), .drop_o(drop_o)
  );

  // FIFO model: read data appears the cycle after rd_req
  logic [BUS-1:0] fifo_mem [0:63];
  int push_ptr = 0;
  int pop_ptr  = 0;
  int rd_cnt   = 0;
  assign is_empty = (push_ptr == pop_ptr);

  always @(posedge clk) begin
    if (rd_req) begin
      rd_cnt <= rd_cnt + 1;
      if (pop_ptr != push_ptr) begin
        data_i  <= fifo_mem[pop_ptr];
        pop_ptr <= pop_ptr + 1;
      end
    end
  end

  // Expected offers, written by stimulus, consumed by the monitor
  logic [BUS-1:0] exp_flit [0:63];
  int exp_port [0:63];
  int exp_wr_idx   = 0;
  int exp_rd_total = 0;
  int exp_drop     = 0;
  int chk_req      = 0;

  // Downstream receiver: accepts after hold_cycles, optional wrong-port pulse
  int   hold_cycles = 0;
  logic wrong_pulse = 1'b0;
  int   hold_cnt    = 0;

  always @(negedge clk) begin
    r_ready_in = '0;
    if (a_rst && wr_ready_out != '0) begin
      if (hold_cnt >= hold_cycles) begin
        r_ready_in = wr_ready_out;
        hold_cnt   = 0;
      end else begin
        if (wrong_pulse && hold_cnt == 3) r_ready_in = 5'b00100;
        hold_cnt++;
      end
    end else begin
      hold_cnt = 0;
    end
  end

  // Monitor / scoreboard
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   cyc         = 0;
  int   rd_rise_cyc = 0;
  int   drop_cnt    = 0;
  int   exp_rd_idx  = 0;
  int   chk_done    = 0;
  logic rd_prev     = 1'b0;
  logic active      = 1'b0;
  logic [NP-1:0] cur_wr = '0;
  logic [DW-1:0] cur_data = '0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  always @(negedge clk or negedge a_rst) begin
    if (!a_rst) begin
      #1;
      check("rst_wr_ready", 256'(wr_ready_out), 256'(1'b0));
      check("rst_data_o",   256'(data_o),       256'(1'b0));
      check("rst_rd_req",   256'(rd_req),       256'(1'b0));
      check("rst_drop_o",   256'(drop_o),       256'(1'b0));
      active  = 1'b0;
      rd_prev = 1'b0;
    end else begin
      cyc++;
      if (rd_req && !rd_prev) rd_rise_cyc = cyc;
      rd_prev = rd_req;
      if (drop_o) drop_cnt++;
      if (wr_ready_out != '0) begin
        check("no_pop_while_offered", 256'(rd_req), 256'(1'b0));
        if (!active) begin
          active = 1'b1;
          if (exp_rd_idx == exp_wr_idx) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_offer: got wr_ready_out=%b, expected none", wr_ready_out);
            cur_wr   = '0;
            cur_data = '0;
          end else begin
            cur_wr   = '0;
            cur_wr[exp_port[exp_rd_idx]] = 1'b1;
            cur_data = '0;
            cur_data[exp_port[exp_rd_idx]*BUS +: BUS] = exp_flit[exp_rd_idx];
            exp_rd_idx++;
            check("offer_port",    256'(wr_ready_out), 256'(cur_wr));
            check("offer_data",    256'(data_o),       256'(cur_data));
            check("offer_latency", 256'(cyc - rd_rise_cyc), 256'(2));
          end
        end else begin
          check("hold_port", 256'(wr_ready_out), 256'(cur_wr));
          check("hold_data", 256'(data_o),       256'(cur_data));
        end
      end else begin
        active = 1'b0;
      end
      if (chk_done != chk_req) begin
        check("rd_req_count",    256'(rd_cnt),       256'(exp_rd_total));
        check("drop_count",      256'(drop_cnt),     256'(exp_drop));
        check("offers_consumed", 256'(exp_rd_idx),   256'(exp_wr_idx));
        check("idle_wr_ready",   256'(wr_ready_out), 256'(1'b0));
        chk_done = chk_req;
      end
    end
  end

  // port < 0: the flit is expected to be dropped, not offered
  task automatic push_flit(input logic [31:0] pl, input logic last, input logic [4:0] dest,
                           input int port);
    logic [BUS-1:0] f;
    f = {pl, last, dest};
    if (port >= 0) begin
      exp_flit[exp_wr_idx] = f;
      exp_port[exp_wr_idx] = port;
      exp_wr_idx++;
    end
    fifo_mem[push_ptr] = f;
    push_ptr++;
    exp_rd_total++;
  endtask

  task automatic checkpoint();
    chk_req++;
    for (int i = 0; i < 4 && chk_done != chk_req; i++) @(posedge clk);
    if (chk_done != chk_req) begin
      $display("FAIL checkpoint: got no monitor response, expected one");
      $fatal(1);
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 a_rst = 1'b1;

    // Single-flit local packet
    @(negedge clk);
    push_flit(32'hA5A5A5A5, 1'b1, 5'd5, 4);
    repeat (15) @(negedge clk);
    checkpoint();

    // 3-flit packet: body flits carry dest 0 but follow the head to port 0
    push_flit(32'h11111111, 1'b0, 5'd7, 0);
    push_flit(32'h22222222, 1'b0, 5'd0, 0);
    push_flit(32'h33333333, 1'b1, 5'd0, 0);
    repeat (25) @(negedge clk);
    checkpoint();

    // Route checks
    push_flit(32'h0000000E, 1'b1, 5'd14, 0);
    push_flit(32'h0000000D, 1'b1, 5'd13, 2);
    push_flit(32'h00000004, 1'b1, 5'd4,  1);
    push_flit(32'h00000001, 1'b1, 5'd1,  3);
    repeat (30) @(negedge clk);
    checkpoint();

    // Backpressure with a wrong-port accept pulse
    hold_cycles = 10;
    wrong_pulse = 1'b1;
    push_flit(32'hBEEFCAFE, 1'b1, 5'd7, 0);
    repeat (25) @(negedge clk);
    checkpoint();
    hold_cycles = 0;
    wrong_pulse = 1'b0;

    // Unroutable 2-flit packet, then a normal one
    exp_drop = 1;
    push_flit(32'hDEAD0001, 1'b0, 5'd20, -1);
    push_flit(32'hDEAD0002, 1'b1, 5'd3,  -1);
    push_flit(32'h0000AAAA, 1'b1, 5'd5,  4);
    repeat (25) @(negedge clk);
    checkpoint();

    // Reset while the body flit is being offered
    push_flit(32'h44444444, 1'b0, 5'd7, 0);
    push_flit(32'h55555555, 1'b0, 5'd0, 0);
    for (int i = 0; i < 20 && rd_cnt != exp_rd_total; i++) @(negedge clk);
    hold_cycles = 1000;
    repeat (3) @(posedge clk);
    #2 a_rst = 1'b0;
    repeat (2) @(posedge clk);
    hold_cycles = 0;
    #2 a_rst = 1'b1;
    @(negedge clk);
    push_flit(32'h66666666, 1'b1, 5'd13, 2);
    repeat (20) @(negedge clk);
    checkpoint();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flit_sender.md
# flit_sender

Output stage of the switch. Pops flits from the switch's input FIFO and routes each packet with XY dimension-order routing over a 2-D mesh. Presents each flit to the selected neighbour (or local) port using the same ready/accept handshake that neighbouring receivers consume. Wormhole style: the head flit picks the port, and every flit up to and including the last flit goes out on that port.

## Interface
Parameters:
- DATA_SIZE, 32, payload bits per flit
- ADDR_SIZE, 4, destination address bits
- X_SIZE, 4, mesh columns
- Y_SIZE, 4, mesh rows
- NODE_ADDR, 0, this node's address (x = NODE_ADDR % X_SIZE, y = NODE_ADDR / X_SIZE)
- PORTS_NUM, 4 (localparam, fixed): ports 0 = east (+x), 1 = west (−x), 2 = south (+y), 3 = north (−y), 4 = local
- BUS_SIZE, DATA_SIZE+ADDR_SIZE+1 (localparam)

Ports:
- clk  in  1  single clock, all state on rising edge
- a_rst  in  1  asynchronous, active-low reset
- is_empty  in  1  FIFO empty flag
- data_i  in  BUS_SIZE  FIFO read data, valid the cycle after rd_req
- rd_req  out  1  FIFO pop request, one-cycle pulse
- r_ready_in  in  PORTS_NUM+1  per-port accept pulse from downstream receiver
- wr_ready_out  out  PORTS_NUM+1  per-port "flit offered" flag, one-hot or zero
- data_o  out  (PORTS_NUM+1)*BUS_SIZE  per-port flit slice; non-selected slices are zero
- drop_o  out  1  one-cycle pulse when an unroutable packet's last flit is discarded

## Operation
Flit format:
- [ADDR_SIZE-1:0]: destination
- [ADDR_SIZE]: last flag
- [BUS_SIZE-1:ADDR_SIZE+1]: payload

The destination field is used only on head flits (locked=0). Body flits' address field is ignored.

State machine (all outputs registered):
- IDLE
  - If !is_empty → FETCH.
- FETCH
  - rd_req=1 for this cycle only → CAPTURE.
- CAPTURE
  - Register data_i into the flit register.
  - If locked=0 (head flit):
    - Compute the route and set locked=1.
    - If dest ≥ X_SIZE*Y_SIZE, set dropping=1.
  - If dropping: discard the flit.
    - If last: pulse drop_o, clear dropping and locked.
    - Next state → IDLE.
  - Otherwise → SEND.
- SEND
  - wr_ready_out[port]=1 and data_o slice `port` = flit; all other slices zero.
  - Hold until r_ready_in[port]=1, then deassert wr_ready_out on the next edge.
  - If the flit is last, clear locked. Next state → IDLE.
  - r_ready_in on any other port is ignored.
  - r_ready_in[port] seen in a non-SEND state is ignored.

XY route (dx, dy = destination coordinates; cx, cy = this node's coordinates):
- dx>cx → port 0
- dx<cx → port 1
- else dy>cy → port 2
- else dy<cy → port 3
- else → port 4
- Unsigned compare at ADDR_SIZE width.

Other rules:
- Port register: reset value 4; holds its value between flits of a packet.

Reset (a_rst low, any state, takes effect immediately and asynchronously):
- state=IDLE, rd_req=0, wr_ready_out=0, data_o=0, drop_o=0, locked=0, dropping=0, port=4.
- An in-flight flit is lost; no partial handshake resumes after reset.

## Timing
- Edge k: IDLE samples is_empty=0 → FETCH. Cycle k..k+1: rd_req=1.
- Edge k+2: data_i captured → SEND. wr_ready_out high from edge k+2; the head flit's port is valid in the same cycle.
- Latency from is_empty falling to wr_ready_out rising: 2 cycles after the sampling edge.
- Best-case throughput: one flit per 4 cycles (IDLE, FETCH, CAPTURE, SEND with r_ready_in present in the first SEND cycle).
- Backpressure: wr_ready_out and data_o stay stable for any number of cycles until accept.
- Exactly one rd_req per flit; rd_req is never asserted while is_empty=1 was sampled.
- A pop never occurs while a flit is held in SEND; the flit register has no overwrite path.
- Drop path: no wr_ready_out activity. drop_o rises the cycle after CAPTURE of the last flit.

## Test plan
All scenarios use X_SIZE=4, Y_SIZE=4, NODE_ADDR=5 (x1,y1) unless stated.

- Single-flit packet dest=5, last=1, payload 0xA5A5A5A5:
  - wr_ready_out=5'b10000 two cycles after FETCH.
  - data_o slice 4 = flit; slices 0–3 zero.
  - After an r_ready_in[4] pulse: wr_ready_out=0 next cycle; state back to IDLE.
- 3-flit packet, head dest=7, body flits carry dest field 0:
  - All three flits are offered on port 0.
  - Exactly 3 rd_req pulses.
  - locked clears after the third accept.
- Route checks, one single-flit packet each:
  - dest 14 → port 0 (x resolved first)
  - dest 13 → port 2
  - dest 4 → port 1
  - dest 1 → port 3
- Backpressure: hold r_ready_in=0 for 10 cycles during SEND.
  - wr_ready_out and data_o remain constant.
  - No rd_req while held.
  - A pulse on r_ready_in[2] (wrong port) is ignored.
- ADDR_SIZE=5, 2-flit packet with dest=20:
  - No wr_ready_out assertion.
  - 2 rd_req pulses; single drop_o pulse after the last flit.
  - The next packet, dest=5, routes normally to port 4.
- Reset mid-packet: pull a_rst low during SEND of the body flit.
  - All outputs zero immediately and asynchronously.
  - After release, a new head flit dest=13 routes to port 2. The stale lock is not reused.
